mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 2, clocks from issue to read data valid at the memory port.
REQ-002 clock  in  1  single system clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 frame_flag  in  1  one-cycle pulse at frame start; swaps buffers.
REQ-005 ntsc_flag  in  1  write request pulse; ntsc_x in LOG_WIDTH, ntsc_y in LOG_HEIGHT, ntsc_pixel_write in LOG_MEM.
REQ-006 done_ntsc  out  1  one-cycle pulse when the ntsc write has been issued to memory.
REQ-007 lpf_flag  in  1  read request pulse; lpf_x in LOG_WIDTH, lpf_y in LOG_HEIGHT.
REQ-008 done_lpf  out  1  one-cycle pulse; lpf_pixel_read out LOG_MEM valid that cycle.
REQ-009 vga_flag  in  1  read request pulse; vga_x in LOG_WIDTH, vga_y in LOG_HEIGHT.
REQ-010 done_vga  out  1  one-cycle pulse; vga_pixel_read out LOG_MEM valid that cycle.
REQ-011 mem_addr out LOG_ADDR, mem_we out 1, mem_write_data out LOG_MEM, mem_read_data in LOG_MEM: memory port, one op per clock.
REQ-012 overrun  out  1  sticky: a flag arrived while that requester was already pending.

Function
REQ-013 Each requester SHALL have a pending bit, set on its flag, with x, y and write data captured that cycle.
REQ-014 Each cycle at most one pending requester SHALL be granted; priority: vga first, then ntsc/lpf by round-robin (last-served loses ties).
REQ-015 Grant SHALL drive mem_addr = {buf, y, x[LOG_WIDTH-1:1]} (concatenation, no multiply); LOG_ADDR = LOG_HEIGHT+LOG_WIDTH.
REQ-016 buf: ntsc uses wr_buf; lpf and vga use ~wr_buf.
REQ-017 mem_we SHALL be 1 only in an ntsc grant cycle; mem_write_data = captured word.
REQ-018 No grant: mem_we = 0; mem_addr and mem_write_data hold their previous values.
REQ-019 A flag SHALL be grantable no earlier than the cycle after it is captured (registered request, no combinational flag-to-grant path).
REQ-020 done_ntsc SHALL pulse the cycle after its grant.
REQ-021 Read grants SHALL push a requester tag into a MEM_LATENCY-deep tag pipe; on tag exit, mem_read_data is registered into that requester's *_pixel_read and its done pulses the same cycle.
REQ-022 *_pixel_read SHALL hold until that requester's next done.
REQ-023 Pending bit SHALL clear on grant; flag in the grant cycle of the same requester sets pending again and is not overrun.
REQ-024 Flag while pending (not in grant cycle) SHALL be ignored and set overrun.
REQ-025 frame_flag SHALL toggle wr_buf and clear all pending bits; flags in the same cycle are captured afterwards and use the new buffer.
REQ-026 Ops already issued at frame_flag SHALL complete; their done pulses and data are delivered normally.
REQ-027 Throughput: one vga-only stream every 2 clocks SHALL leave every other cycle for ntsc/lpf.

Reset
REQ-028 Reset SHALL clear pending bits, tag pipe, wr_buf, round-robin pointer, overrun.
REQ-029 Reset values: all done_* = 0, mem_we = 0, mem_addr = 0, mem_write_data = 0, *_pixel_read = 0.
REQ-030 Reset mid-operation SHALL discard in-flight reads; no done pulse follows reset.

Structure
REQ-031 LOG_ADDR, MEM_LATENCY default and requester tag codes (NONE, NTSC, LPF, VGA) SHALL live in params.v.
REQ-032 The tag pipe SHALL be the existing delay sub-module (N=MEM_LATENCY, LOG=2); no other sub-modules.

Verification
REQ-033 lpf_flag at (x=5,y=3), wr_buf=0 -> next cycle mem_addr={1,3,2}, mem_we=0; done_lpf 2 cycles later with mem_read_data echoed.
REQ-034 ntsc_flag and lpf_flag same cycle, then again -> grants alternate ntsc, lpf, ntsc, lpf; done_ntsc 1 cycle after each ntsc grant.
REQ-035 vga, ntsc, lpf flagged same cycle -> vga granted first, then ntsc, then lpf; no cycle with two grants.
REQ-036 lpf_flag twice on consecutive cycles before grant -> second ignored, overrun=1 until reset.
REQ-037 frame_flag with lpf pending and one read in flight -> pending dropped, in-flight done_lpf delivered, wr_buf toggles.
REQ-038 reset asserted one cycle after a read grant -> no done_lpf, all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, requester tag codes and pending-bit helpers for the
// frame-buffer memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_LOG_WIDTH   = 4;
    localparam int DEF_LOG_HEIGHT  = 3;
    localparam int DEF_LOG_MEM     = 8;
    localparam int DEF_MEM_LATENCY = 2;
    localparam int DEF_LOG_ADDR    = DEF_LOG_HEIGHT + DEF_LOG_WIDTH;
    localparam int TAG_W           = 2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_NTSC = 2'd1,
        TAG_LPF  = 2'd2,
        TAG_VGA  = 2'd3
    } tag_e;

    // A flag is taken when the slot is free, is being granted now, or is being flushed by frame start.
    function automatic logic flag_accept(input logic flag, input logic pend,
                                         input logic gnt, input logic frame);
        return flag & (~pend | gnt | frame);
    endfunction

    function automatic logic pend_keep(input logic pend, input logic gnt, input logic frame);
        return pend & ~gnt & ~frame;
    endfunction

endpackage

// File: rtl/mem_arbiter_delay.sv
// N-stage registered delay line used as the read-tag pipe.
module mem_arbiter_delay #(
    parameter int N   = 2,
    parameter int LOG = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [LOG-1:0] d_i,
    output logic [LOG-1:0] q_o
);

    logic [LOG-1:0] stage_q [N];

    // Shift register; reset drops everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= {LOG{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port frame-buffer arbiter: ntsc writes into wr_buf while lpf and vga
// read from the other buffer; vga has priority, ntsc/lpf share round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOG_WIDTH   = DEF_LOG_WIDTH,
    parameter int LOG_HEIGHT  = DEF_LOG_HEIGHT,
    parameter int LOG_MEM     = DEF_LOG_MEM,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_flag,
    input  logic                            ntsc_flag,
    input  logic [LOG_WIDTH-1:0]            ntsc_x,
    input  logic [LOG_HEIGHT-1:0]           ntsc_y,
    input  logic [LOG_MEM-1:0]              ntsc_pixel_write,
    output logic                            done_ntsc,
    input  logic                            lpf_flag,
    input  logic [LOG_WIDTH-1:0]            lpf_x,
    input  logic [LOG_HEIGHT-1:0]           lpf_y,
    output logic                            done_lpf,
    output logic [LOG_MEM-1:0]              lpf_pixel_read,
    input  logic                            vga_flag,
    input  logic [LOG_WIDTH-1:0]            vga_x,
    input  logic [LOG_HEIGHT-1:0]           vga_y,
    output logic                            done_vga,
    output logic [LOG_MEM-1:0]              vga_pixel_read,
    output logic [LOG_HEIGHT+LOG_WIDTH-1:0] mem_addr,
    output logic                            mem_we,
    output logic [LOG_MEM-1:0]              mem_write_data,
    input  logic [LOG_MEM-1:0]              mem_read_data,
    output logic                            overrun
);

    localparam int AW = LOG_HEIGHT + LOG_WIDTH;
    localparam int XW = LOG_WIDTH - 1;

    logic            ntsc_pend_q, lpf_pend_q, vga_pend_q;
    logic            ntsc_pend_d, lpf_pend_d, vga_pend_d;
    logic            ntsc_cap_d, lpf_cap_d, vga_cap_d;
    logic [XW-1:0]   ntsc_x_q, lpf_x_q, vga_x_q;
    logic [LOG_HEIGHT-1:0] ntsc_y_q, lpf_y_q, vga_y_q;
    logic [LOG_MEM-1:0] ntsc_data_q, wdata_q, wdata_d;
    logic [LOG_MEM-1:0] lpf_pix_q, vga_pix_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_buf_q, ntsc_last_q, overrun_q, done_ntsc_q;
    logic            gnt_vga_d, gnt_ntsc_d, gnt_lpf_d, ovr_d;
    logic [TAG_W-1:0] tag_in_d, tag_out;
    logic            unused_x_lsb;

    assign unused_x_lsb = ^{ntsc_x[0], lpf_x[0], vga_x[0]};

    // Arbitration and memory-port drive; only registered state feeds this.
    always_comb begin
        gnt_vga_d  = vga_pend_q;
        gnt_ntsc_d = 1'b0;
        gnt_lpf_d  = 1'b0;
        if (!vga_pend_q) begin
            if (ntsc_pend_q && lpf_pend_q) begin
                gnt_ntsc_d = ~ntsc_last_q;
                gnt_lpf_d  = ntsc_last_q;
            end else begin
                gnt_ntsc_d = ntsc_pend_q;
                gnt_lpf_d  = lpf_pend_q;
            end
        end else begin
            gnt_ntsc_d = 1'b0;
            gnt_lpf_d  = 1'b0;
        end

        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_in_d = TAG_NONE;
        if (gnt_vga_d) begin
            addr_d   = {~wr_buf_q, vga_y_q, vga_x_q};
            tag_in_d = TAG_VGA;
        end else if (gnt_ntsc_d) begin
            addr_d   = {wr_buf_q, ntsc_y_q, ntsc_x_q};
            wdata_d  = ntsc_data_q;
        end else if (gnt_lpf_d) begin
            addr_d   = {~wr_buf_q, lpf_y_q, lpf_x_q};
            tag_in_d = TAG_LPF;
        end else begin
            addr_d   = addr_q;
        end

        ntsc_cap_d  = flag_accept(ntsc_flag, ntsc_pend_q, gnt_ntsc_d, frame_flag);
        lpf_cap_d   = flag_accept(lpf_flag, lpf_pend_q, gnt_lpf_d, frame_flag);
        vga_cap_d   = flag_accept(vga_flag, vga_pend_q, gnt_vga_d, frame_flag);
        ntsc_pend_d = ntsc_cap_d | pend_keep(ntsc_pend_q, gnt_ntsc_d, frame_flag);
        lpf_pend_d  = lpf_cap_d | pend_keep(lpf_pend_q, gnt_lpf_d, frame_flag);
        vga_pend_d  = vga_cap_d | pend_keep(vga_pend_q, gnt_vga_d, frame_flag);
        ovr_d       = (ntsc_flag & ~ntsc_cap_d) | (lpf_flag & ~lpf_cap_d) | (vga_flag & ~vga_cap_d);
    end

    // Request capture, buffer select, round-robin pointer and output holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ntsc_pend_q <= 1'b0;
            lpf_pend_q  <= 1'b0;
            vga_pend_q  <= 1'b0;
            ntsc_x_q    <= {XW{1'b0}};
            lpf_x_q     <= {XW{1'b0}};
            vga_x_q     <= {XW{1'b0}};
            ntsc_y_q    <= {LOG_HEIGHT{1'b0}};
            lpf_y_q     <= {LOG_HEIGHT{1'b0}};
            vga_y_q     <= {LOG_HEIGHT{1'b0}};
            ntsc_data_q <= {LOG_MEM{1'b0}};
            wdata_q     <= {LOG_MEM{1'b0}};
            addr_q      <= {AW{1'b0}};
            lpf_pix_q   <= {LOG_MEM{1'b0}};
            vga_pix_q   <= {LOG_MEM{1'b0}};
            wr_buf_q    <= 1'b0;
            ntsc_last_q <= 1'b0;
            overrun_q   <= 1'b0;
            done_ntsc_q <= 1'b0;
        end else begin
            ntsc_pend_q <= ntsc_pend_d;
            lpf_pend_q  <= lpf_pend_d;
            vga_pend_q  <= vga_pend_d;
            if (ntsc_cap_d) begin
                ntsc_x_q    <= ntsc_x[LOG_WIDTH-1:1];
                ntsc_y_q    <= ntsc_y;
                ntsc_data_q <= ntsc_pixel_write;
            end
            if (lpf_cap_d) begin
                lpf_x_q <= lpf_x[LOG_WIDTH-1:1];
                lpf_y_q <= lpf_y;
            end
            if (vga_cap_d) begin
                vga_x_q <= vga_x[LOG_WIDTH-1:1];
                vga_y_q <= vga_y;
            end
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_buf_q    <= wr_buf_q ^ frame_flag;
            overrun_q   <= overrun_q | ovr_d;
            done_ntsc_q <= gnt_ntsc_d;
            if (gnt_ntsc_d) begin
                ntsc_last_q <= 1'b1;
            end else if (gnt_lpf_d) begin
                ntsc_last_q <= 1'b0;
            end
            if (done_lpf) begin
                lpf_pix_q <= mem_read_data;
            end
            if (done_vga) begin
                vga_pix_q <= mem_read_data;
            end
        end
    end

    mem_arbiter_delay #(
        .N   (MEM_LATENCY),
        .LOG (TAG_W)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .d_i   (tag_in_d),
        .q_o   (tag_out)
    );

    // Read data is presented on the tag-exit cycle and held afterwards.
    assign done_lpf       = (tag_out == TAG_LPF);
    assign done_vga       = (tag_out == TAG_VGA);
    assign lpf_pixel_read = done_lpf ? mem_read_data : lpf_pix_q;
    assign vga_pixel_read = done_vga ? mem_read_data : vga_pix_q;
    assign done_ntsc      = done_ntsc_q;
    assign mem_addr       = addr_d;
    assign mem_we         = gnt_ntsc_d;
    assign mem_write_data = wdata_d;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-clock-latency memory whose read
// data is {1'b1, addr}.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_flag = 1'b0;
    logic       ntsc_flag = 1'b0, lpf_flag = 1'b0, vga_flag = 1'b0;
    logic [3:0] ntsc_x = 4'd0, lpf_x = 4'd0, vga_x = 4'd0;
    logic [2:0] ntsc_y = 3'd0, lpf_y = 3'd0, vga_y = 3'd0;
    logic [7:0] ntsc_pixel_write = 8'd0;
    logic       done_ntsc, done_lpf, done_vga, mem_we, overrun;
    logic [7:0] lpf_pixel_read, vga_pixel_read, mem_write_data, mem_read_data;
    logic [DEF_LOG_ADDR-1:0] mem_addr;
    logic [7:0] rd_p0 = 8'd0, rd_p1 = 8'd0;
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rd_p0 <= {1'b1, mem_addr};
        rd_p1 <= rd_p0;
    end
    assign mem_read_data = rd_p1;

    mem_arbiter dut (
        .clock (clock), .reset (reset), .frame_flag (frame_flag),
        .ntsc_flag (ntsc_flag), .ntsc_x (ntsc_x), .ntsc_y (ntsc_y),
        .ntsc_pixel_write (ntsc_pixel_write), .done_ntsc (done_ntsc),
        .lpf_flag (lpf_flag), .lpf_x (lpf_x), .lpf_y (lpf_y),
        .done_lpf (done_lpf), .lpf_pixel_read (lpf_pixel_read),
        .vga_flag (vga_flag), .vga_x (vga_x), .vga_y (vga_y),
        .done_vga (done_vga), .vga_pixel_read (vga_pixel_read),
        .mem_addr (mem_addr), .mem_we (mem_we), .mem_write_data (mem_write_data),
        .mem_read_data (mem_read_data), .overrun (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        frame_flag = 1'b0;
        ntsc_flag  = 1'b0;
        lpf_flag   = 1'b0;
        vga_flag   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done_ntsc"}, {31'd0, done_ntsc}, 32'd0);
        chk({tag, "_done_lpf"}, {31'd0, done_lpf}, 32'd0);
        chk({tag, "_done_vga"}, {31'd0, done_vga}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, {25'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, mem_write_data}, 32'd0);
        chk({tag, "_lpf_pix"}, {24'd0, lpf_pixel_read}, 32'd0);
        chk({tag, "_vga_pix"}, {24'd0, vga_pixel_read}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        next_cycle();
        next_cycle();
        chk_reset_vals("rst");
        reset = 1'b0;

        // single lpf read at x=5,y=3
        next_cycle(); lpf_flag = 1'b1; lpf_x = 4'd5; lpf_y = 3'd3;
        chk("lpf_cap_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        chk("lpf_addr", {25'd0, mem_addr}, 32'h5A);
        chk("lpf_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        chk("lpf_done_early", {31'd0, done_lpf}, 32'd0);
        chk("lpf_addr_hold", {25'd0, mem_addr}, 32'h5A);
        next_cycle();
        chk("lpf_done", {31'd0, done_lpf}, 32'd1);
        chk("lpf_data", {24'd0, lpf_pixel_read}, 32'hDA);
        next_cycle();
        chk("lpf_done_one", {31'd0, done_lpf}, 32'd0);
        chk("lpf_data_hold", {24'd0, lpf_pixel_read}, 32'hDA);

        // ntsc/lpf round robin
        next_cycle();
        ntsc_flag = 1'b1; ntsc_x = 4'd2; ntsc_y = 3'd1; ntsc_pixel_write = 8'h11;
        lpf_flag = 1'b1; lpf_x = 4'd7; lpf_y = 3'd6;
        next_cycle();
        chk("rr1_addr", {25'd0, mem_addr}, 32'h09);
        chk("rr1_we", {31'd0, mem_we}, 32'd1);
        chk("rr1_wdata", {24'd0, mem_write_data}, 32'h11);
        next_cycle();
        chk("rr2_addr", {25'd0, mem_addr}, 32'h73);
        chk("rr2_we", {31'd0, mem_we}, 32'd0);
        chk("rr2_done_ntsc", {31'd0, done_ntsc}, 32'd1);
        ntsc_flag = 1'b1; ntsc_x = 4'd4; ntsc_y = 3'd2; ntsc_pixel_write = 8'h22;
        lpf_flag = 1'b1; lpf_x = 4'd9; lpf_y = 3'd5;
        next_cycle();
        chk("rr3_addr", {25'd0, mem_addr}, 32'h12);
        chk("rr3_we", {31'd0, mem_we}, 32'd1);
        chk("rr3_wdata", {24'd0, mem_write_data}, 32'h22);
        chk("rr3_done_ntsc", {31'd0, done_ntsc}, 32'd0);
        next_cycle();
        chk("rr4_addr", {25'd0, mem_addr}, 32'h6C);
        chk("rr4_we", {31'd0, mem_we}, 32'd0);
        chk("rr4_done_ntsc", {31'd0, done_ntsc}, 32'd1);
        chk("rr4_done_lpf", {31'd0, done_lpf}, 32'd1);
        chk("rr4_lpf_data", {24'd0, lpf_pixel_read}, 32'hF3);
        chk("rr4_overrun", {31'd0, overrun}, 32'd0);
        next_cycle();
        chk("idle_we", {31'd0, mem_we}, 32'd0);
        chk("idle_addr_hold", {25'd0, mem_addr}, 32'h6C);
        chk("idle_wdata_hold", {24'd0, mem_write_data}, 32'h22);
        next_cycle();
        chk("rr_lpf2_done", {31'd0, done_lpf}, 32'd1);
        chk("rr_lpf2_data", {24'd0, lpf_pixel_read}, 32'hEC);

        // vga, ntsc, lpf in the same cycle
        next_cycle();
        vga_flag = 1'b1; vga_x = 4'd3; vga_y = 3'd7;
        ntsc_flag = 1'b1; ntsc_x = 4'd0; ntsc_y = 3'd0; ntsc_pixel_write = 8'h33;
        lpf_flag = 1'b1; lpf_x = 4'd15; lpf_y = 3'd0;
        next_cycle();
        chk("pri_vga_addr", {25'd0, mem_addr}, 32'h79);
        chk("pri_vga_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        chk("pri_ntsc_addr", {25'd0, mem_addr}, 32'h00);
        chk("pri_ntsc_we", {31'd0, mem_we}, 32'd1);
        chk("pri_ntsc_wdata", {24'd0, mem_write_data}, 32'h33);
        next_cycle();
        chk("pri_lpf_addr", {25'd0, mem_addr}, 32'h47);
        chk("pri_lpf_we", {31'd0, mem_we}, 32'd0);
        chk("pri_done_vga", {31'd0, done_vga}, 32'd1);
        chk("pri_vga_data", {24'd0, vga_pixel_read}, 32'hF9);
        chk("pri_done_ntsc", {31'd0, done_ntsc}, 32'd1);
        next_cycle();
        chk("pri_idle_we", {31'd0, mem_we}, 32'd0);
        chk("pri_vga_done_one", {31'd0, done_vga}, 32'd0);
        next_cycle();
        chk("pri_done_lpf", {31'd0, done_lpf}, 32'd1);
        chk("pri_lpf_data", {24'd0, lpf_pixel_read}, 32'hC7);

        // frame start with lpf pending and an lpf read in flight
        next_cycle(); lpf_flag = 1'b1; lpf_x = 4'd2; lpf_y = 3'd2;
        next_cycle();
        chk("frm_lpf_addr", {25'd0, mem_addr}, 32'h51);
        vga_flag = 1'b1; vga_x = 4'd6; vga_y = 3'd4;
        lpf_flag = 1'b1; lpf_x = 4'd8; lpf_y = 3'd1;
        next_cycle();
        chk("frm_vga_addr", {25'd0, mem_addr}, 32'h63);
        frame_flag = 1'b1;
        next_cycle();
        chk("frm_drop_we", {31'd0, mem_we}, 32'd0);
        chk("frm_drop_addr", {25'd0, mem_addr}, 32'h63);
        chk("frm_done_lpf", {31'd0, done_lpf}, 32'd1);
        chk("frm_lpf_data", {24'd0, lpf_pixel_read}, 32'hD1);
        next_cycle();
        chk("frm_done_vga", {31'd0, done_vga}, 32'd1);
        chk("frm_vga_data", {24'd0, vga_pixel_read}, 32'hE3);
        chk("frm_lpf_quiet", {31'd0, done_lpf}, 32'd0);
        next_cycle();
        chk("frm_still_idle", {31'd0, mem_we}, 32'd0);
        ntsc_flag = 1'b1; ntsc_x = 4'd6; ntsc_y = 3'd5; ntsc_pixel_write = 8'h44;
        lpf_flag = 1'b1; lpf_x = 4'd1; lpf_y = 3'd1;
        next_cycle();
        chk("newbuf_ntsc_addr", {25'd0, mem_addr}, 32'h6B);
        chk("newbuf_ntsc_we", {31'd0, mem_we}, 32'd1);
        next_cycle();
        chk("newbuf_lpf_addr", {25'd0, mem_addr}, 32'h08);
        chk("newbuf_overrun", {31'd0, overrun}, 32'd0);

        // overrun: second lpf flag while still pending behind vga
        next_cycle();
        vga_flag = 1'b1; vga_x = 4'd0; vga_y = 3'd0;
        lpf_flag = 1'b1; lpf_x = 4'd4; lpf_y = 3'd3;
        next_cycle();
        chk("ovr_vga_addr", {25'd0, mem_addr}, 32'h00);
        chk("ovr_before", {31'd0, overrun}, 32'd0);
        lpf_flag = 1'b1; lpf_x = 4'd12; lpf_y = 3'd7;
        next_cycle();
        chk("ovr_first_kept", {25'd0, mem_addr}, 32'h1A);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        next_cycle();
        frame_flag = 1'b1;
        ntsc_flag = 1'b1; ntsc_x = 4'd2; ntsc_y = 3'd0; ntsc_pixel_write = 8'h55;
        next_cycle();
        chk("frm_same_cycle_addr", {25'd0, mem_addr}, 32'h01);
        chk("frm_same_cycle_we", {31'd0, mem_we}, 32'd1);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // reset one cycle after a read grant
        next_cycle();
        frame_flag = 1'b1; lpf_flag = 1'b1; lpf_x = 4'd3; lpf_y = 3'd3;
        next_cycle();
        chk("rst_lpf_addr", {25'd0, mem_addr}, 32'h19);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        chk_reset_vals("midrst");
        reset = 1'b0;
        next_cycle();
        chk("midrst_no_done", {31'd0, done_lpf}, 32'd0);
        chk("midrst_pix", {24'd0, lpf_pixel_read}, 32'd0);
        ntsc_flag = 1'b1; ntsc_x = 4'd0; ntsc_y = 3'd4; ntsc_pixel_write = 8'h66;
        next_cycle();
        chk("midrst_wrbuf_addr", {25'd0, mem_addr}, 32'h20);
        chk("midrst_wdata", {24'd0, mem_write_data}, 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
